vlc_bitstream_packer: RTL and testbench
=======================================

// Module: vlc_bitstream_packer
// PURPOSE
//  Packs the variable-length codewords (right-aligned value + bit length) emitted by the DC/AC entropy
//  coders into a contiguous MSB-first bitstream of 32-bit words. Sits directly downstream of the
//  DC-coefficient VLC stage; output feeds the slice writer. Handles backpressure and end-of-slice flush
//  with zero padding to a byte boundary.
// PARAMETERS
//  CODE_W  32  max codeword width; also output word width
//  LEN_W   6   width of length field (0..CODE_W)
//  ACC_W   64  accumulator width (= 2*CODE_W)
// PORTS
//  clk         in   1       clock; all state on rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  in_valid    in   1       codeword beat valid
//  in_ready    out  1       packer can accept a beat
//  in_code     in   CODE_W  codeword, right-aligned; bits at/above in_len ignored (masked)
//  in_len      in   LEN_W   codeword length in bits; upstream 32-bit length truncated to LEN_W bits
//  in_flush    in   1       with accepted beat: append in_code, then drain/pad slice
//  out_valid   out  1       out_data valid
//  out_ready   in   1       consumer accepts word
//  out_data    out  CODE_W  packed bits, first bit of stream at MSB
//  out_bytes   out  3       valid bytes in out_data (1..4)
//  out_last    out  1       final word of flushed slice
//  flush_done  out  1       one-cycle pulse when flush completes
//  bit_count   out  32      bits accepted since reset/last flush_done (wraps)
// BEHAVIOUR
//  - Reset (async): acc=0, fill=0, state=RUN; out_valid=0, out_data=0, out_bytes=0, out_last=0,
//    flush_done=0, bit_count=0; in_ready=1 after release. Reset mid-slice discards partial bits; no word emitted.
//  - Accept = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (state==RUN) & (fill <= CODE_W); registered-state function, no dependency on in_valid.
//  - in_len>CODE_W saturates to CODE_W; in_len==0 accepted, no bit change (flush still honoured).
//  - Same-cycle pop+accept: fill' = fill - 32 on pop; code placed at acc bit (ACC_W-1-fill') downward;
//    acc<<=32 on pop; fill_next = fill' + len.
//  - RUN: out_valid = (fill >= 32); out_data = acc[63:32], out_bytes=4, out_last=0.
//    Latency: beat accepted at edge N completing 32 bits -> out_valid at N+1.
//  - Accept with in_flush: append code, go to DRAIN; in_ready=0 while not RUN.
//  - DRAIN: out_valid = (fill > 0); out_data = acc[63:32] (unused low bits already zero);
//    out_bytes = fill>=32 ? 4 : ceil(fill/8); out_last = (fill <= 32).
//    On pop with out_last, or entering DRAIN with fill==0: fill=0, acc=0, flush_done=1 next cycle,
//    bit_count=0, state=RUN. Empty flush emits no word, only flush_done.
//  - out_* held stable while out_valid & !out_ready (AXI-style; no drop/duplicate).
//  - Invariant: 0 <= fill <= 64; never overflows given in_ready rule.
//  - bit_count += len on every accept (32-bit wrap).
// STRUCTURE
//  - Shared package vlc_pkg: CODE_W, LEN_W, ACC_W, state encodings (ST_RUN, ST_DRAIN),
//    len_saturate/ceil_bytes functions; reused by other VLC stages.
//  - One sub-module: vlc_bit_aligner (combinational): mask in_code to in_len, shift into
//    ACC_W position given fill'; returns aligned vector to OR into acc.
//  - Top: FSM, fill counter, accumulator, output register, bit_count.
// TESTING
//  1 reset held then released -> out_valid=0, in_ready=1, bit_count=0, flush_done=0.
//  2 codes 0xA5,0x3C,0xFF,0x01 each len 8, out_ready=1 -> one word 0xA53CFF01, bytes=4, last=0 one cycle after 4th beat.
//  3 0x5 len3, then 0x1 len1+flush -> word 0xB0000000, out_bytes=1, out_last=1; flush_done next cycle; bit_count=0.
//  4 out_ready=0, three beats 0xFFFFFFFF len32 -> 3rd stalls (in_ready=0 at fill=64); release -> 2 words,
//    3rd accepted, order preserved, no loss.
//  5 0xFFFFFFFF len4 + 0x0 len28 -> word 0xF0000000 (upper garbage masked); len0 beat changes nothing.
//  6 fill=20 then reset_n low mid-cycle -> outputs clear immediately (async); after release no stale word.

Source files
------------

// File: rtl/vlc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vlc_pkg
// Purpose  : Shared constants, state encoding and helper functions for the
//            VLC entropy-coding stages (codeword widths, packer FSM states,
//            length saturation, bit-to-byte rounding).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vlc_pkg;

  localparam int CODE_W = 32;                 // max codeword / output word width
  localparam int LEN_W  = 6;                  // codeword length field width
  localparam int ACC_W  = 2 * CODE_W;         // packing accumulator width
  localparam int FILL_W = $clog2(ACC_W + 1);  // holds 0..ACC_W

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } vlc_state_e;

  // Lengths above the codeword width are clamped to the codeword width.
  function automatic logic [LEN_W-1:0] len_saturate(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(CODE_W)) begin
      return LEN_W'(CODE_W);
    end
    return len;
  endfunction

  // Number of bytes needed to hold 'bits' bits (rounded up).
  function automatic logic [2:0] ceil_bytes(input logic [FILL_W-1:0] bits);
    return 3'((bits + FILL_W'(7)) >> 3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vlc_bit_aligner.sv
`default_nettype none
// ============================================================================
// Module   : vlc_bit_aligner
// Purpose  : Masks a right-aligned codeword to its length and positions it in
//            the accumulator so its first bit lands just below the bits
//            already held (MSB-first packing).
// Ports    : code    in  CODE_W  right-aligned codeword (bits >= len ignored)
//            len     in  LEN_W   saturated codeword length (0..CODE_W)
//            fill    in  FILL_W  bits already held in accumulator (0..CODE_W)
//            aligned out ACC_W   codeword placed at bit (ACC_W-1-fill) downward
// Revision : 1.0 - initial release
// ============================================================================
module vlc_bit_aligner
  import vlc_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic [LEN_W-1:0]  len,
  input  logic [FILL_W-1:0] fill,
  output logic [ACC_W-1:0]  aligned
);

  logic [CODE_W-1:0] w_mask;
  logic [CODE_W-1:0] w_masked;
  logic [FILL_W-1:0] w_shift;

  always_comb begin
    w_mask   = (len >= LEN_W'(CODE_W)) ? '1 : ((CODE_W'(1) << len) - CODE_W'(1));
    w_masked = code & w_mask;
    // Left shift so the codeword MSB (bit len-1) ends at ACC_W-1-fill.
    // len==0 gives a full-width shift, which yields zero as intended.
    w_shift  = FILL_W'(ACC_W) - fill - FILL_W'(len);
    aligned  = {{(ACC_W-CODE_W){1'b0}}, w_masked} << w_shift;
  end

endmodule
`default_nettype wire

// File: rtl/vlc_bitstream_packer.sv
`default_nettype none
// ============================================================================
// Module   : vlc_bitstream_packer
// Purpose  : Packs variable-length codewords into an MSB-first stream of
//            CODE_W-bit words with backpressure; an accepted beat carrying
//            in_flush drains the slice, zero-padding the last word to a byte
//            boundary. Widths come from vlc_pkg (CODE_W, LEN_W, ACC_W).
// Ports    : clk, reset_n (async active-low)
//            in_valid/in_ready/in_code/in_len/in_flush   codeword input
//            out_valid/out_ready/out_data/out_bytes/out_last  word output
//            flush_done  one-cycle pulse at end of slice flush
//            bit_count   bits accepted since reset / last flush_done
// Revision : 1.0 - initial release
// ============================================================================
module vlc_bitstream_packer
  import vlc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_data,
  output logic [2:0]        out_bytes,
  output logic              out_last,
  output logic              flush_done,
  output logic [31:0]       bit_count
);

  vlc_state_e        r_state, w_state_n;
  logic [ACC_W-1:0]  r_acc, w_acc_n, w_acc_pop, w_aligned;
  logic [FILL_W-1:0] r_fill, w_fill_n, w_fill_pop;
  logic [31:0]       r_bit_count, w_bit_count_n;
  logic              r_flush_done, w_flush_done_n;
  logic [LEN_W-1:0]  w_len;
  logic              w_pop, w_accept, w_full_word;

  // Outputs are decoded straight from registered state, so they stay stable
  // while a word is stalled (accepts only touch bits below the output word).
  assign w_full_word = (r_fill >= FILL_W'(CODE_W));
  assign in_ready    = (r_state == ST_RUN) && (r_fill <= FILL_W'(CODE_W));
  assign out_valid   = (r_state == ST_RUN) ? w_full_word : (r_fill != '0);
  assign out_data    = r_acc[ACC_W-1 -: CODE_W];
  assign out_last    = (r_state == ST_DRAIN) && (r_fill <= FILL_W'(CODE_W));
  assign out_bytes   = !out_valid                         ? 3'd0 :
                       ((r_state == ST_RUN) || w_full_word) ? 3'd4 :
                       ceil_bytes(r_fill);
  assign flush_done  = r_flush_done;
  assign bit_count   = r_bit_count;

  assign w_pop       = out_valid & out_ready;
  assign w_accept    = in_valid & in_ready;
  assign w_len       = len_saturate(in_len);

  // A pop frees the top word first; the incoming code is then placed
  // relative to the post-pop fill so pop and accept can share a cycle.
  assign w_fill_pop  = w_pop ? (r_fill - FILL_W'(CODE_W)) : r_fill;
  assign w_acc_pop   = w_pop ? (r_acc << CODE_W) : r_acc;

  vlc_bit_aligner u_aligner (
    .code    (in_code),
    .len     (w_len),
    .fill    (w_fill_pop),
    .aligned (w_aligned)
  );

  always_comb begin
    w_state_n      = r_state;
    w_acc_n        = w_acc_pop;
    w_fill_n       = w_fill_pop;
    w_bit_count_n  = r_bit_count;
    w_flush_done_n = 1'b0;

    if (w_accept) begin
      w_acc_n       = w_acc_pop | w_aligned;
      w_fill_n      = w_fill_pop + FILL_W'(w_len);
      w_bit_count_n = r_bit_count + 32'(w_len);
    end

    case (r_state)
      ST_RUN: begin
        if (w_accept && in_flush) begin
          if (w_fill_n == '0) begin
            // Nothing left to send: the flush completes without a word.
            w_acc_n        = '0;
            w_bit_count_n  = '0;
            w_flush_done_n = 1'b1;
          end else begin
            w_state_n = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_pop && out_last) begin
          w_state_n      = ST_RUN;
          w_acc_n        = '0;
          w_fill_n       = '0;
          w_bit_count_n  = '0;
          w_flush_done_n = 1'b1;
        end
      end
      default: w_state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_RUN;
      r_acc        <= '0;
      r_fill       <= '0;
      r_bit_count  <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_acc        <= w_acc_n;
      r_fill       <= w_fill_n;
      r_bit_count  <= w_bit_count_n;
      r_flush_done <= w_flush_done_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vlc_bitstream_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vlc_bitstream_packer
// Purpose  : Self-checking bench for vlc_bitstream_packer. A bit-queue model
//            of the stream predicts every emitted word, handshake readiness,
//            bit_count and flush_done; directed scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vlc_bitstream_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_code = '0;
  logic [5:0]  in_len = '0;
  logic        in_flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_last;
  logic        flush_done;
  logic [31:0] bit_count;

  vlc_bitstream_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_len     (in_len),
    .in_flush   (in_flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_bytes  (out_bytes),
    .out_last   (out_last),
    .flush_done (flush_done),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: the stream as a queue of bits --------
  bit          mq[$];
  bit          m_draining = 1'b0;
  bit          m_exp_fd   = 1'b0;
  int unsigned m_bits     = 0;
  bit          mon_en     = 1'b0;
  bit          rand_ready = 1'b0;

  task automatic model_reset();
    mq.delete();
    m_draining = 1'b0;
    m_exp_fd   = 1'b0;
    m_bits     = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      int          n;
      int          sz;
      int          l;
      logic [31:0] w;
      logic        last;
      logic [2:0]  bytes;

      sz = mq.size();
      chk_eq("in_ready", 64'(in_ready), 64'(!m_draining && sz <= 32));
      chk_eq("out_valid", 64'(out_valid), 64'(m_draining ? (sz > 0) : (sz >= 32)));
      chk_eq("bit_count", 64'(bit_count), 64'(m_bits));
      if (flush_done || m_exp_fd) chk_eq("flush_done", 64'(flush_done), 64'(m_exp_fd));
      m_exp_fd = 1'b0;

      // The popped word is the oldest bits in the stream; a pop is resolved
      // before a same-cycle accept because the new code lies behind it.
      if (out_valid && out_ready) begin
        n     = (sz < 32) ? sz : 32;
        last  = m_draining && (sz <= 32);
        bytes = (!m_draining || sz >= 32) ? 3'd4 : 3'((sz + 7) / 8);
        w     = '0;
        for (int i = 0; i < n; i++) w[31-i] = mq.pop_front();
        chk_eq("word_data", 64'(out_data), 64'(w));
        chk_eq("word_bytes", 64'(out_bytes), 64'(bytes));
        chk_eq("word_last", 64'(out_last), 64'(last));
        if (last) begin
          mq.delete();
          m_draining = 1'b0;
          m_bits     = 0;
          m_exp_fd   = 1'b1;
        end
      end

      if (in_valid && in_ready) begin
        l = (in_len > 6'd32) ? 32 : int'(in_len);
        for (int i = l - 1; i >= 0; i--) mq.push_back(in_code[i]);
        m_bits += l;
        if (in_flush) begin
          if (mq.size() == 0) begin
            m_bits   = 0;
            m_exp_fd = 1'b1;
          end else begin
            m_draining = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge + 1) --------------
  task automatic send(input logic [31:0] c, input logic [5:0] l, input logic f);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_code  = c;
    in_len   = l;
    in_flush = f;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 500) begin
        chk_eq("send_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_valid || !in_ready) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) chk_eq("idle_timeout", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
    chk_eq("rst_in_ready", 64'(in_ready), 64'd1);
    chk_eq("rst_bit_count", 64'(bit_count), 64'd0);
    chk_eq("rst_flush_done", 64'(flush_done), 64'd0);
    chk_eq("rst_out_bytes", 64'(out_bytes), 64'd0);
    model_reset();
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // 2: four bytes form one word, visible right after the 4th accept
    send(32'hA5, 6'd8, 1'b0);
    send(32'h3C, 6'd8, 1'b0);
    send(32'hFF, 6'd8, 1'b0);
    send(32'h01, 6'd8, 1'b0);
    chk_eq("t2_valid", 64'(out_valid), 64'd1);
    chk_eq("t2_data", 64'(out_data), 64'hA53CFF01);
    chk_eq("t2_bytes", 64'(out_bytes), 64'd4);
    chk_eq("t2_last", 64'(out_last), 64'd0);

    // 3: short flushed slice is padded to a byte
    send(32'h5, 6'd3, 1'b0);
    send(32'h1, 6'd1, 1'b1);
    chk_eq("t3_data", 64'(out_data), 64'hB0000000);
    chk_eq("t3_bytes", 64'(out_bytes), 64'd1);
    chk_eq("t3_last", 64'(out_last), 64'd1);
    @(posedge clk);
    #1;
    chk_eq("t3_flush_done", 64'(flush_done), 64'd1);
    chk_eq("t3_bit_count", 64'(bit_count), 64'd0);
    wait_idle();

    // 4: backpressure stalls the third full-width beat without loss
    out_ready = 1'b0;
    send(32'hFFFFFFFF, 6'd32, 1'b0);
    send(32'hFFFFFFFF, 6'd32, 1'b0);
    fork
      send(32'hFFFFFFFF, 6'd32, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk_eq("t4_stall_ready", 64'(in_ready), 64'd0);
        chk_eq("t4_stall_data", 64'(out_data), 64'hFFFFFFFF);
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // 5: bits above len are masked; a zero-length beat changes nothing
    send(32'hFFFFFFFF, 6'd4, 1'b0);
    send(32'h0, 6'd28, 1'b0);
    chk_eq("t5_data", 64'(out_data), 64'hF0000000);
    chk_eq("t5_bit_count", 64'(bit_count), 64'd128);
    send(32'h12345678, 6'd0, 1'b0);
    chk_eq("t5_len0_bit_count", 64'(bit_count), 64'd128);
    chk_eq("t5_len0_valid", 64'(out_valid), 64'd0);

    // empty flush: pulse only, no word
    send(32'h0, 6'd0, 1'b1);
    chk_eq("empty_flush_done", 64'(flush_done), 64'd1);
    chk_eq("empty_flush_valid", 64'(out_valid), 64'd0);
    wait_idle();

    // 6: asynchronous reset in the middle of a partial word
    send(32'hABCDE, 6'd20, 1'b0);
    chk_eq("t6_partial_data", 64'(out_data), 64'hABCDE000);
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_eq("t6_async_data", 64'(out_data), 64'd0);
    chk_eq("t6_async_valid", 64'(out_valid), 64'd0);
    chk_eq("t6_async_bit_count", 64'(bit_count), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_eq("t6_no_stale_word", 64'(out_valid), 64'd0);

    // random traffic with random backpressure and occasional flushes
    rand_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      logic [5:0] l;
      int         g;
      l = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(33, 63))
                                      : 6'($urandom_range(0, 32));
      send($urandom, l, $urandom_range(0, 7) == 0);
      g = $urandom_range(0, 3);
      if (g > 1) begin
        repeat (g - 1) begin
          @(posedge clk);
          #1;
        end
      end
    end
    send($urandom, 6'($urandom_range(1, 32)), 1'b1);
    wait_idle();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_idle();
    chk_eq("end_bit_count", 64'(bit_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
